qsys_epcs_nios2_oci_mem_access: RTL and testbench

Debug-side OCI memory access engine for the Nios II debug module. It consumes the JTAG debug module's sysclk-domain command outputs (`jdo`, `take_action_ocimem_*`), performs reads and writes on the debug on-chip RAM, and returns `MonDReg`, `monitor_ready` and `monitor_error` to that module's inputs. It also arbitrates the same RAM port against the CPU's debug-slave accesses, with JTAG taking priority.

---
 rtl/qsys_epcs_nios2_oci_pkg.sv | 28 ++
 rtl/qsys_epcs_nios2_oci_mem_access.sv | 162 ++++++++++++++++
 tb/tb_qsys_epcs_nios2_oci_mem_access.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/qsys_epcs_nios2_oci_pkg.sv
// Shared definitions for the Nios II OCI debug memory access path.
//   - Default debug RAM geometry (word address / data widths)
//   - Field positions inside the 38-bit JTAG command payload (jdo)
//   - State encoding of the memory access arbiter
package qsys_epcs_nios2_oci_pkg;

    localparam int unsigned OCI_ADDR_W = 8;
    localparam int unsigned OCI_DATA_W = 32;
    localparam int unsigned JDO_W      = 38;

    // jdo field layout; the address field sits inside the write-data field,
    // which is harmless because the two are never used by the same command.
    localparam int unsigned JDO_ADDR_LSB  = 18;
    localparam int unsigned JDO_WDATA_LSB = 3;
    localparam int unsigned JDO_RD_BIT    = 35;
    localparam int unsigned JDO_CLR_BIT   = 36;

    typedef enum logic [2:0] {
        IDLE,
        J_RD,
        J_RDW,
        J_WR,
        C_RD,
        C_RDW,
        C_WR
    } oci_state_t;

endpackage

// File: rtl/qsys_epcs_nios2_oci_mem_access.sv
// Debug-side OCI memory access engine.
// Executes JTAG debug commands (address load / read / write with
// auto-increment) against the debug on-chip RAM and shares the same RAM port
// with the CPU debug slave; JTAG wins when both request from IDLE.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   jdo, take_*_ocimem_*         JTAG command payload and command pulses
//   MonDReg, monitor_ready/error JTAG read data, completion and overrun flags
//   avs_*                        CPU debug-slave port (waitrequest handshake)
//   ociram_*                     debug RAM port (read data one cycle after rd)
module qsys_epcs_nios2_oci_mem_access
    import qsys_epcs_nios2_oci_pkg::*;
#(
    parameter int unsigned ADDR_W = OCI_ADDR_W,
    parameter int unsigned DATA_W = OCI_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ociram_addr,
    output logic [DATA_W-1:0] ociram_wrdata,
    output logic              ociram_wr,
    output logic              ociram_rd,
    input  logic [DATA_W-1:0] ociram_rddata
);

    oci_state_t        state;
    logic [ADDR_W-1:0] mon_a_reg;
    logic              pend_rd;
    logic              pend_wr;
    logic [DATA_W-1:0] pend_wdata;

    logic [ADDR_W-1:0] jdo_addr;
    logic [DATA_W-1:0] jdo_wdata;
    logic [ADDR_W-1:0] cur_addr;
    logic              addr_only;
    logic              rd_cmd;
    logic              wr_cmd;
    logic              jtag_busy;
    logic              accept_rd;
    logic              accept_wr;
    logic              overrun;
    logic              cpu_done;

    logic unused_jdo;
    assign unused_jdo = ^{jdo[JDO_W-1], jdo[JDO_WDATA_LSB-1:0]};

    always_comb begin
        jdo_addr  = jdo[JDO_ADDR_LSB +: ADDR_W];
        jdo_wdata = jdo[JDO_WDATA_LSB +: DATA_W];
        addr_only = take_action_ocimem_a & ~jdo[JDO_RD_BIT];
        rd_cmd    = (take_action_ocimem_a & jdo[JDO_RD_BIT]) | take_no_action_ocimem_a;
        wr_cmd    = take_action_ocimem_b;
        jtag_busy = pend_rd | pend_wr
                  | (state == J_RD) | (state == J_RDW) | (state == J_WR);
        // A read and a write in the same cycle: the read is taken, the write overruns.
        accept_rd = rd_cmd & ~jtag_busy;
        accept_wr = wr_cmd & ~jtag_busy & ~rd_cmd;
        overrun   = (rd_cmd & jtag_busy) | (wr_cmd & (jtag_busy | rd_cmd));
        // A read issued together with an address load uses the new address.
        cur_addr  = take_action_ocimem_a ? jdo_addr : mon_a_reg;
        cpu_done  = (state == C_RDW) | (state == C_WR);
    end

    assign avs_waitrequest = (avs_read | avs_write) & ~cpu_done;
    assign avs_readdata    = (state == C_RDW) ? ociram_rddata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            mon_a_reg     <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            pend_rd       <= 1'b0;
            pend_wr       <= 1'b0;
            pend_wdata    <= '0;
            ociram_addr   <= '0;
            ociram_wrdata <= '0;
            ociram_wr     <= 1'b0;
            ociram_rd     <= 1'b0;
        end else begin
            ociram_rd <= 1'b0;
            ociram_wr <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (pend_rd | accept_rd) begin
                        state       <= J_RD;
                        ociram_rd   <= 1'b1;
                        ociram_addr <= pend_rd ? mon_a_reg : cur_addr;
                        pend_rd     <= 1'b0;
                    end else if (pend_wr | accept_wr) begin
                        state         <= J_WR;
                        ociram_wr     <= 1'b1;
                        ociram_addr   <= mon_a_reg;
                        ociram_wrdata <= pend_wr ? pend_wdata : jdo_wdata;
                        pend_wr       <= 1'b0;
                    end else if (avs_read) begin
                        state       <= C_RD;
                        ociram_rd   <= 1'b1;
                        ociram_addr <= avs_address;
                    end else if (avs_write) begin
                        state         <= C_WR;
                        ociram_wr     <= 1'b1;
                        ociram_addr   <= avs_address;
                        ociram_wrdata <= avs_writedata;
                    end
                end
                J_RD:  state <= J_RDW;
                J_RDW: begin
                    MonDReg       <= ociram_rddata;
                    monitor_ready <= 1'b1;
                    mon_a_reg     <= mon_a_reg + ADDR_W'(1);
                    state         <= IDLE;
                end
                J_WR: begin
                    monitor_ready <= 1'b1;
                    mon_a_reg     <= mon_a_reg + ADDR_W'(1);
                    state         <= IDLE;
                end
                C_RD:    state <= C_RDW;
                C_RDW:   state <= IDLE;
                C_WR:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // Commands accepted while the CPU owns the RAM are parked until IDLE.
            if (state != IDLE) begin
                if (accept_rd) pend_rd <= 1'b1;
                if (accept_wr) begin
                    pend_wr    <= 1'b1;
                    pend_wdata <= jdo_wdata;
                end
            end

            // Ordering matters: a new command's ready-clear overrides an
            // address-only completion, and an address load overrides the
            // post-access increment.
            if (addr_only)              monitor_ready <= 1'b1;
            if (accept_rd | accept_wr)  monitor_ready <= 1'b0;
            if (take_action_ocimem_a & (addr_only | accept_rd)) begin
                mon_a_reg <= jdo_addr;
                if (jdo[JDO_CLR_BIT]) monitor_error <= 1'b0;
            end
            if (overrun) monitor_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_qsys_epcs_nios2_oci_mem_access.sv
module tb_qsys_epcs_nios2_oci_mem_access;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_a, take_na, take_b;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;
    logic [7:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata, avs_readdata;
    logic        avs_waitrequest;
    logic [7:0]  ociram_addr;
    logic [31:0] ociram_wrdata, ociram_rddata;
    logic        ociram_wr, ociram_rd;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    // Debug RAM model with a bench-side preload port
    logic [31:0] mem [256];
    logic [31:0] rd_q = '0;
    int          rd_count = 0;
    logic        pl_we;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (ociram_wr) mem[ociram_addr] <= ociram_wrdata;
        if (ociram_rd) begin
            rd_q     <= mem[ociram_addr];
            rd_count <= rd_count + 1;
        end
    end
    assign ociram_rddata = rd_q;

    qsys_epcs_nios2_oci_mem_access #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .jdo                    (jdo),
        .take_action_ocimem_a   (take_a),
        .take_no_action_ocimem_a(take_na),
        .take_action_ocimem_b   (take_b),
        .MonDReg                (MonDReg),
        .monitor_ready          (monitor_ready),
        .monitor_error          (monitor_error),
        .avs_address            (avs_address),
        .avs_read               (avs_read),
        .avs_write              (avs_write),
        .avs_writedata          (avs_writedata),
        .avs_readdata           (avs_readdata),
        .avs_waitrequest        (avs_waitrequest),
        .ociram_addr            (ociram_addr),
        .ociram_wrdata          (ociram_wrdata),
        .ociram_wr              (ociram_wr),
        .ociram_rd              (ociram_rd),
        .ociram_rddata          (ociram_rddata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] jdo_a(bit clr, bit rd, logic [7:0] addr);
        logic [37:0] j;
        j = '0;
        j[36] = clr;
        j[35] = rd;
        j[25:18] = addr;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic preload(logic [7:0] a, logic [31:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_we = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL reset_mondreg got %h want %h", MonDReg, 32'h0); end
        checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", monitor_ready); end
        checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", monitor_error); end
        checks++; if ({ociram_rd, ociram_wr} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {ociram_rd, ociram_wr}); end
        checks++; if (avs_readdata !== 32'h0) begin errors++; $display("FAIL reset_avs_readdata got %h want 0", avs_readdata); end
        @(negedge clk) reset_n = 1'b1;
        step();
        checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL reset_release_ready got %b want 0", monitor_ready); end
    endtask

    task automatic test_addr_read();
        exp_q.push_back(32'hDEADBEEF);
        jdo = jdo_a(1'b0, 1'b1, 8'h10); take_a = 1'b1;
        step(); take_a = 1'b0;
        checks++; if ({ociram_rd, ociram_addr} !== {1'b1, 8'h10}) begin errors++; $display("FAIL rd_strobe_t1 got %b/%h want 1/10", ociram_rd, ociram_addr); end
        step();
        checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL rd_ready_t2 got %b want 0", monitor_ready); end
        step();
        exp_v = exp_q.pop_front();
        checks++; if (monitor_ready !== 1'b1) begin errors++; $display("FAIL rd_ready_t3 got %b want 1", monitor_ready); end
        checks++; if (MonDReg !== exp_v) begin errors++; $display("FAIL rd_data got %h want %h", MonDReg, exp_v); end
        // next read must land on the incremented address
        exp_q.push_back(32'h11111111);
        take_na = 1'b1; step(); take_na = 1'b0;
        checks++; if ({ociram_rd, ociram_addr} !== {1'b1, 8'h11}) begin errors++; $display("FAIL rd_incr_addr got %b/%h want 1/11", ociram_rd, ociram_addr); end
        step(); step();
        exp_v = exp_q.pop_front();
        checks++; if (MonDReg !== exp_v || monitor_ready !== 1'b1) begin errors++; $display("FAIL rd_incr_data got %h/%b want %h/1", MonDReg, monitor_ready, exp_v); end
    endtask

    task automatic test_burst_wrap();
        jdo = jdo_a(1'b0, 1'b0, 8'hFF); take_a = 1'b1;
        step(); take_a = 1'b0;
        checks++; if (monitor_ready !== 1'b1) begin errors++; $display("FAIL addr_only_ready got %b want 1", monitor_ready); end
        jdo = jdo_b(32'h1); take_b = 1'b1;
        step(); take_b = 1'b0;
        checks++; if ({ociram_wr, ociram_addr, monitor_ready} !== {1'b1, 8'hFF, 1'b0}) begin errors++; $display("FAIL wr_ff got %b/%h/%b want 1/ff/0", ociram_wr, ociram_addr, monitor_ready); end
        step();
        checks++; if (monitor_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_t2 got %b want 1", monitor_ready); end
        jdo = jdo_b(32'h2); take_b = 1'b1;
        step(); take_b = 1'b0;
        checks++; if ({ociram_wr, ociram_addr} !== {1'b1, 8'h00}) begin errors++; $display("FAIL wr_wrap got %b/%h want 1/00", ociram_wr, ociram_addr); end
        step();
        checks++; if (mem[8'hFF] !== 32'h1) begin errors++; $display("FAIL ram_ff got %h want 1", mem[8'hFF]); end
        checks++; if (mem[8'h00] !== 32'h2) begin errors++; $display("FAIL ram_00 got %h want 2", mem[8'h00]); end
        exp_q.push_back(32'h01010101);
        take_na = 1'b1; step(); take_na = 1'b0;
        checks++; if (ociram_addr !== 8'h01) begin errors++; $display("FAIL wrap_next_addr got %h want 01", ociram_addr); end
        step(); step();
        exp_v = exp_q.pop_front();
        checks++; if (MonDReg !== exp_v) begin errors++; $display("FAIL wrap_read got %h want %h", MonDReg, exp_v); end
    endtask

    task automatic test_overrun();
        int n0;
        bit ok;
        n0 = rd_count;
        exp_q.push_back(32'h22222222);
        take_na = 1'b1; step(); step(); take_na = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (monitor_ready === 1'b1) begin ok = 1'b1; break; end
            step();
        end
        checks++; if (!ok) begin errors++; $display("FAIL overrun_timeout got ready=%b want 1", monitor_ready); end
        exp_v = exp_q.pop_front();
        checks++; if (monitor_error !== 1'b1) begin errors++; $display("FAIL overrun_error got %b want 1", monitor_error); end
        checks++; if (rd_count - n0 != 1) begin errors++; $display("FAIL overrun_rd_count got %0d want 1", rd_count - n0); end
        checks++; if (MonDReg !== exp_v) begin errors++; $display("FAIL overrun_data got %h want %h", MonDReg, exp_v); end
        jdo = jdo_a(1'b1, 1'b0, 8'h20); take_a = 1'b1;
        step(); take_a = 1'b0;
        checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL error_clear got %b want 0", monitor_error); end
    endtask

    task automatic test_simultaneous();
        int hi;
        bit ok;
        exp_q.push_back(32'h5);
        avs_address = 8'h20; avs_read = 1'b1;
        jdo = jdo_b(32'h5); take_b = 1'b1;
        step(); take_b = 1'b0;
        checks++; if ({ociram_wr, ociram_rd} !== 2'b10) begin errors++; $display("FAIL simul_jtag_first got wr/rd %b want 10", {ociram_wr, ociram_rd}); end
        hi = 0; ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (avs_waitrequest === 1'b0) begin ok = 1'b1; break; end
            hi++;
            step();
        end
        exp_v = exp_q.pop_front();
        checks++; if (!ok || hi != 3) begin errors++; $display("FAIL simul_wait got %0d cycles (done=%b) want 3", hi, ok); end
        checks++; if (avs_readdata !== exp_v) begin errors++; $display("FAIL simul_cpu_data got %h want %h", avs_readdata, exp_v); end
        checks++; if (monitor_ready !== 1'b1) begin errors++; $display("FAIL simul_ready got %b want 1", monitor_ready); end
        avs_read = 1'b0;
        step();
    endtask

    task automatic test_jtag_during_cpu();
        exp_q.push_back(32'h00003030);
        avs_address = 8'h30; avs_read = 1'b1;
        step(); step();
        exp_v = exp_q.pop_front();
        checks++; if ({avs_waitrequest, avs_readdata} !== {1'b0, exp_v}) begin errors++; $display("FAIL cpu_rd got %b/%h want 0/%h", avs_waitrequest, avs_readdata, exp_v); end
        exp_q.push_back(32'h21212121);
        take_na = 1'b1; step(); take_na = 1'b0; avs_read = 1'b0;
        checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL park_ready_t1 got %b want 0", monitor_ready); end
        step();
        checks++; if ({ociram_rd, ociram_addr} !== {1'b1, 8'h21}) begin errors++; $display("FAIL park_rd_t2 got %b/%h want 1/21", ociram_rd, ociram_addr); end
        step();
        checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL park_ready_t3 got %b want 0", monitor_ready); end
        step();
        exp_v = exp_q.pop_front();
        checks++; if ({monitor_ready, MonDReg} !== {1'b1, exp_v}) begin errors++; $display("FAIL park_done_t4 got %b/%h want 1/%h", monitor_ready, MonDReg, exp_v); end
    endtask

    task automatic test_reset_mid();
        int n0;
        int seen;
        take_na = 1'b1; step(); take_na = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        checks++; if ({MonDReg, monitor_ready, monitor_error, ociram_rd, ociram_wr} !== 36'h0) begin errors++; $display("FAIL midreset_outs got %h/%b/%b/%b/%b want all 0", MonDReg, monitor_ready, monitor_error, ociram_rd, ociram_wr); end
        @(negedge clk) reset_n = 1'b1;
        n0 = rd_count; seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (monitor_ready === 1'b1) seen++;
        end
        checks++; if (seen != 0 || rd_count != n0) begin errors++; $display("FAIL midreset_quiet got ready=%0d rd=%0d want 0/0", seen, rd_count - n0); end
        avs_address = 8'h50; avs_writedata = 32'h55; avs_write = 1'b1;
        #1;
        checks++; if (avs_waitrequest !== 1'b1) begin errors++; $display("FAIL cpu_wr_wait got %b want 1", avs_waitrequest); end
        step();
        checks++; if ({avs_waitrequest, ociram_wr, ociram_addr} !== {1'b0, 1'b1, 8'h50}) begin errors++; $display("FAIL cpu_wr_grant got %b/%b/%h want 0/1/50", avs_waitrequest, ociram_wr, ociram_addr); end
        avs_write = 1'b0;
        step();
        checks++; if (mem[8'h50] !== 32'h55) begin errors++; $display("FAIL cpu_wr_ram got %h want 55", mem[8'h50]); end
        exp_q.push_back(32'h2);
        take_na = 1'b1; step(); take_na = 1'b0;
        checks++; if (ociram_addr !== 8'h00) begin errors++; $display("FAIL midreset_addr got %h want 00", ociram_addr); end
        step(); step();
        exp_v = exp_q.pop_front();
        checks++; if (MonDReg !== exp_v) begin errors++; $display("FAIL midreset_read got %h want %h", MonDReg, exp_v); end
    endtask

    initial begin
        reset_n = 1'b0; jdo = '0;
        take_a = 1'b0; take_na = 1'b0; take_b = 1'b0;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        test_reset();
        preload(8'h10, 32'hDEADBEEF);
        preload(8'h11, 32'h11111111);
        preload(8'h01, 32'h01010101);
        preload(8'h02, 32'h22222222);
        preload(8'h20, 32'h0000FFFF);
        preload(8'h21, 32'h21212121);
        preload(8'h30, 32'h00003030);
        test_addr_read();
        test_burst_wrap();
        test_overrun();
        test_simultaneous();
        test_jtag_during_cpu();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
